// File: rtl/load_align_unit.sv
// Load alignment unit: turns a RISC-V load (funct3 + byte address) into one or
// two aligned memory reads, then shifts, truncates and sign/zero-extends the
// result. One load is in flight at a time; loads that cross a word boundary
// either split into two beats or fault, depending on ALLOW_MISALIGNED.
module load_align_unit #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_fnc,
    input  logic [31:0]     req_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [31:0]     mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err
);

    localparam int unsigned BYTES    = XLEN / 8;
    localparam int unsigned OFFW     = $clog2(BYTES);
    localparam int unsigned IDXW     = $clog2(2 * XLEN);
    localparam logic [31:0] BYTES_W  = 32'(BYTES);
    localparam logic [31:0] OFF_MASK = BYTES_W - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        fnc_q, fnc_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [31:0]       base_q, base_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [31:0]       mem_req_addr_q, mem_req_addr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    // Request decode
    logic [3:0]        req_size;
    logic [OFFW-1:0]   req_off;
    logic              req_misal;
    logic              req_illegal;

    // Alignment datapath
    logic [XLEN-1:0]   lo_word;
    logic [XLEN-1:0]   hi_word;
    logic [2*XLEN-1:0] window;
    logic [IDXW-1:0]   cap_msb;
    logic              fill_bit;
    logic [XLEN-1:0]   aligned;

    assign req_off     = req_addr[OFFW-1:0];
    assign req_misal   = (5'(req_off) + 5'(req_size)) > 5'(BYTES);
    assign req_illegal = (req_fnc == 3'b111) ||
                         ((XLEN == 32) && ((req_fnc == 3'b011) || (req_fnc == 3'b110)));

    // Access size in bytes from the low funct3 bits
    always_comb begin
        case (req_fnc[1:0])
            2'b00:   req_size = 4'd1;
            2'b01:   req_size = 4'd2;
            2'b10:   req_size = 4'd4;
            default: req_size = 4'd8;
        endcase
    end

    // Shift the incoming beat(s) down by the byte offset, then truncate and extend.
    // The final beat is used straight off the bus so the result registers in the
    // same cycle it arrives; only beat0 of a split load needs holding.
    always_comb begin
        lo_word = mem_resp_data;
        hi_word = '0;
        if (state_q == WAIT1) begin
            lo_word = beat0_q;
            hi_word = mem_resp_data;
        end
        window = {hi_word, lo_word} >> {off_q, 3'b000};
        case (fnc_q[1:0])
            2'b00:   cap_msb = IDXW'(7);
            2'b01:   cap_msb = IDXW'(15);
            2'b10:   cap_msb = IDXW'(31);
            default: cap_msb = IDXW'(63);
        endcase
        fill_bit = ~fnc_q[2] & window[cap_msb];
        aligned  = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            aligned[i] = (IDXW'(i) <= cap_msb) ? window[i] : fill_bit;
        end
    end

    // Next-state and next-output logic for the load sequencer
    always_comb begin
        state_d         = state_q;
        fnc_d           = fnc_q;
        off_d           = off_q;
        base_d          = base_q;
        split_d         = split_q;
        beat0_d         = beat0_q;
        req_ready_d     = req_ready_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        resp_valid_d    = resp_valid_q;
        resp_data_d     = resp_data_q;
        resp_err_d      = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    fnc_d       = req_fnc;
                    off_d       = req_off;
                    base_d      = req_addr & ~OFF_MASK;
                    split_d     = req_misal;
                    beat0_d     = '0;
                    req_ready_d = 1'b0;
                    if (req_illegal || (req_misal && !ALLOW_MISALIGNED)) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        state_d         = REQ0;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = req_addr & ~OFF_MASK;
                    end
                end
            end
            REQ0: begin
                if (mem_req_ready) begin
                    state_d         = WAIT0;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT0: begin
                if (mem_resp_valid) begin
                    beat0_d = mem_resp_data;
                    if (split_q) begin
                        state_d         = REQ1;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = base_q + BYTES_W;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = aligned;
                    end
                end
            end
            REQ1: begin
                if (mem_req_ready) begin
                    state_d         = WAIT1;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT1: begin
                if (mem_resp_valid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = aligned;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any load in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            fnc_q           <= '0;
            off_q           <= '0;
            base_q          <= '0;
            split_q         <= 1'b0;
            beat0_q         <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fnc_q           <= fnc_d;
            off_q           <= off_d;
            base_q          <= base_d;
            split_q         <= split_d;
            beat0_q         <= beat0_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_err_q      <= resp_err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit splitting instance under random loads
// against a byte-level memory model, plus a 32-bit no-split instance and a
// 64-bit instance exercised with fixed cases.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: XLEN=32, split allowed
    logic        req_valid, req_ready, mem_req_valid, mem_req_ready;
    logic        mem_resp_valid, resp_valid, resp_ready, resp_err;
    logic [2:0]  req_fnc;
    logic [31:0] req_addr, mem_req_addr, mem_resp_data, resp_data;

    // Instance B: XLEN=32, misaligned loads fault
    logic        req_valid_b, req_ready_b, mem_req_valid_b, mem_req_ready_b;
    logic        mem_resp_valid_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [2:0]  req_fnc_b;
    logic [31:0] req_addr_b, mem_req_addr_b, mem_resp_data_b, resp_data_b;

    // Instance C: XLEN=64
    logic        req_valid_c, req_ready_c, mem_req_valid_c, mem_req_ready_c;
    logic        mem_resp_valid_c, resp_valid_c, resp_ready_c, resp_err_c;
    logic [2:0]  req_fnc_c;
    logic [31:0] req_addr_c, mem_req_addr_c;
    logic [63:0] mem_resp_data_c, resp_data_c;

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fnc(req_fnc), .req_addr(req_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
    );

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_fnc(req_fnc_b), .req_addr(req_addr_b),
        .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready_b), .mem_req_addr(mem_req_addr_b),
        .mem_resp_valid(mem_resp_valid_b), .mem_resp_data(mem_resp_data_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_data(resp_data_b), .resp_err(resp_err_b)
    );

    load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_dut_c (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_c), .req_ready(req_ready_c), .req_fnc(req_fnc_c), .req_addr(req_addr_c),
        .mem_req_valid(mem_req_valid_c), .mem_req_ready(mem_req_ready_c), .mem_req_addr(mem_req_addr_c),
        .mem_resp_valid(mem_resp_valid_c), .mem_resp_data(mem_resp_data_c),
        .resp_valid(resp_valid_c), .resp_ready(resp_ready_c), .resp_data(resp_data_c), .resp_err(resp_err_c)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Words placed at specific aligned addresses; everything else is a hash
    logic [31:0] ovr [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_a(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [7:0] byte_a(input logic [31:0] a);
        logic [31:0] w;
        w = word_a({a[31:2], 2'b00});
        return 8'(w >> (8 * a[1:0]));
    endfunction

    // Reference: gather the addressed bytes one at a time, then extend
    task automatic model(input logic [2:0] fnc, input logic [31:0] addr,
                         output logic [31:0] data, output logic err, output int unsigned nbeats);
        int unsigned size;
        logic [63:0] val;
        size = 1 << fnc[1:0];
        if (fnc == 3'b111 || fnc == 3'b011 || fnc == 3'b110) begin
            data = '0; err = 1'b1; nbeats = 0;
            return;
        end
        val = '0;
        for (int unsigned i = 0; i < size; i++) begin
            val |= 64'(byte_a(addr + i)) << (8 * i);
        end
        if (!fnc[2] && val[8 * size - 1]) val |= ~64'd0 << (8 * size);
        data   = val[31:0];
        err    = 1'b0;
        nbeats = (int'(addr[1:0]) + size > 4) ? 2 : 1;
    endtask

    // One load on instance A with programmable stalls; every cycle is checked
    task automatic do_load(input logic [2:0] fnc, input logic [31:0] addr,
                           input int unsigned req_stall, input int unsigned rsp_dly,
                           input int unsigned resp_stall, input bit chk_lat);
        logic [31:0] exp_data, base, hs_addr, exp_addr;
        logic        exp_err;
        int unsigned nbeats, nreq, stall_left, dly_left, rstall_left;
        bit          hs_pend, rsp_wait, seen_resp, done;
        model(fnc, addr, exp_data, exp_err, nbeats);
        base = addr & 32'hFFFF_FFFC;
        nreq = 0; dly_left = 0; hs_pend = 0; rsp_wait = 0; seen_resp = 0; done = 0;
        hs_addr = '0;
        stall_left  = req_stall;
        rstall_left = resp_stall;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_fnc = fnc; req_addr = addr;
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'($urandom);
        resp_ready = 1'($urandom);
        for (int unsigned cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; req_fnc = 3'($urandom); req_addr = $urandom;
            mem_resp_valid = 1'b0; mem_resp_data = $urandom;
            if (hs_pend) begin
                hs_pend = 0; rsp_wait = 1; dly_left = rsp_dly;
            end
            if (rsp_wait) begin
                if (dly_left == 0) begin
                    mem_resp_valid = 1'b1; mem_resp_data = word_a(hs_addr); rsp_wait = 0;
                end else begin
                    dly_left--;
                end
            end else if ($urandom_range(3) == 0) begin
                mem_resp_valid = 1'b1;
            end
            check("req_ready_busy", req_ready, 0);
            if (mem_req_valid) begin
                exp_addr = base + 32'(4 * nreq);
                check("mem_req_addr", mem_req_addr, exp_addr);
                check("mem_req_extra", nreq < nbeats, 1);
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0; stall_left--;
                end else begin
                    mem_req_ready = 1'b1; hs_pend = 1; hs_addr = mem_req_addr; nreq++;
                    stall_left = req_stall;
                end
            end else begin
                mem_req_ready = 1'($urandom);
            end
            if (resp_valid) begin
                if (!seen_resp) begin
                    seen_resp = 1;
                    if (chk_lat) check("latency", cyc, exp_err ? 1 : (nbeats == 2 ? 5 : 3));
                end
                check("resp_data", resp_data, exp_data);
                check("resp_err", resp_err, exp_err);
                if (rstall_left > 0) begin
                    resp_ready = 1'b0; rstall_left--;
                end else begin
                    resp_ready = 1'b1; done = 1;
                end
            end else begin
                resp_ready = 1'($urandom);
            end
        end
        check("resp_done", done, 1);
        check("mem_beats", nreq, nbeats);
        @(negedge clk);
        resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        check("req_ready_after", req_ready, 1);
        check("resp_valid_after", resp_valid, 0);
    endtask

    // Instance B: faulting loads must answer without touching memory
    task automatic load_b(input logic [2:0] fnc, input logic [31:0] addr);
        bit done;
        done = 0;
        @(negedge clk);
        req_valid_b = 1'b1; req_fnc_b = fnc; req_addr_b = addr; resp_ready_b = 1'b1;
        for (int unsigned cyc = 1; cyc <= 8 && !done; cyc++) begin
            @(negedge clk);
            req_valid_b = 1'b0;
            check("b_no_mem_req", mem_req_valid_b, 0);
            if (resp_valid_b) begin
                check("b_latency", cyc, 1);
                check("b_resp_data", resp_data_b, 0);
                check("b_resp_err", resp_err_b, 1);
                done = 1;
            end
        end
        check("b_done", done, 1);
        @(negedge clk);
        resp_ready_b = 1'b0;
        check("b_req_ready_after", req_ready_b, 1);
    endtask

    // Instance C: aligned 64-bit loads with a single known memory word
    task automatic load_c(input logic [2:0] fnc, input logic [31:0] addr,
                          input logic [63:0] word, input logic [63:0] exp);
        bit hs, done;
        hs = 0; done = 0;
        @(negedge clk);
        req_valid_c = 1'b1; req_fnc_c = fnc; req_addr_c = addr;
        mem_req_ready_c = 1'b1; resp_ready_c = 1'b1;
        for (int unsigned cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            req_valid_c = 1'b0; mem_resp_valid_c = 1'b0;
            if (hs) begin
                mem_resp_valid_c = 1'b1; mem_resp_data_c = word; hs = 0;
            end
            if (mem_req_valid_c) begin
                check("c_mem_req_addr", mem_req_addr_c, {addr[31:3], 3'b000});
                hs = 1;
            end
            if (resp_valid_c) begin
                check("c_resp_data", resp_data_c, exp);
                check("c_resp_err", resp_err_c, 0);
                done = 1;
            end
        end
        check("c_done", done, 1);
        @(negedge clk);
        mem_resp_valid_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_fnc = 0; req_addr = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_data = 0; resp_ready = 0;
        req_valid_b = 0; req_fnc_b = 0; req_addr_b = 0; mem_req_ready_b = 1;
        mem_resp_valid_b = 0; mem_resp_data_b = 0; resp_ready_b = 0;
        req_valid_c = 0; req_fnc_c = 0; req_addr_c = 0; mem_req_ready_c = 0;
        mem_resp_valid_c = 0; mem_resp_data_c = 0; resp_ready_c = 0;

        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Byte load with sign bit set
        ovr[32'h100] = 32'h80FF_1234;
        do_load(3'b000, 32'h103, 0, 0, 0, 1);
        // Halfword straddling two words
        ovr[32'h200] = 32'hAB00_0000;
        ovr[32'h204] = 32'h0000_00CD;
        do_load(3'b101, 32'h203, 0, 0, 0, 1);
        // Memory and result backpressure
        do_load(3'b010, 32'h300, 3, 0, 2, 0);
        // Illegal encodings on a 32-bit unit
        do_load(3'b111, 32'h010, 0, 0, 0, 1);
        do_load(3'b011, 32'h018, 0, 0, 0, 1);
        do_load(3'b110, 32'h020, 0, 0, 0, 1);
        // Second beat wraps the 32-bit address space
        do_load(3'b010, 32'hFFFF_FFFE, 0, 1, 0, 0);

        load_b(3'b010, 32'h102);
        load_b(3'b110, 32'h100);

        load_c(3'b110, 32'h1004, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_FEDC_BA98);
        load_c(3'b010, 32'h1004, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FEDC_BA98);
        load_c(3'b011, 32'h1000, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210);
        load_c(3'b000, 32'h1007, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset while waiting for the second beat of a split load
        @(negedge clk);
        req_valid = 1'b1; req_fnc = 3'b010; req_addr = 32'h1FE;
        mem_req_ready = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_req0_valid", mem_req_valid, 1);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = word_a(32'h1FC);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("abort_req1_addr", mem_req_addr, 32'h200);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_mem_req_valid", mem_req_valid, 0);
        check("abort_mem_req_addr", mem_req_addr, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_data", resp_data, 0);
        check("abort_resp_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("late_resp_valid", resp_valid, 0);
        check("late_mem_req_valid", mem_req_valid, 0);
        check("late_req_ready", req_ready, 1);
        do_load(3'b000, 32'h401, 0, 0, 0, 1);

        // Random loads
        for (int unsigned n = 0; n < 200; n++) begin
            logic [2:0]  fnc;
            logic [31:0] addr;
            fnc  = 3'($urandom_range(7));
            addr = $urandom;
            if ($urandom_range(1) == 1) addr = {20'h0, 12'($urandom)};
            if ($urandom_range(2) == 0)
                do_load(fnc, addr, 0, 0, 0, 1);
            else
                do_load(fnc, addr, $urandom_range(2), $urandom_range(2), $urandom_range(2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data width; legal values 32 and 64.
REQ-002 Parameter ALLOW_MISALIGNED, default 1, SHALL enable split two-beat access (1) or fault (0) for loads crossing an XLEN/8-byte boundary.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid/req_ready  input/output  1/1  load request handshake.
REQ-006 req_fnc  input  3  RISC-V load funct3 (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110).
REQ-007 req_addr  input  32  byte address.
REQ-008 mem_req_valid/mem_req_ready  output/input  1/1  memory read handshake.
REQ-009 mem_req_addr  output  32  address aligned to XLEN/8 bytes.
REQ-010 mem_resp_valid  input  1  memory data valid; no backpressure.
REQ-011 mem_resp_data  input  XLEN  aligned memory word.
REQ-012 resp_valid/resp_ready  output/input  1/1  result handshake.
REQ-013 resp_data  output  XLEN  aligned, extended load result.
REQ-014 resp_err  output  1  illegal fnc or disallowed misalignment; valid with resp_valid.

Function
REQ-015 States SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; one load in flight at most.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid&&req_ready, capturing fnc, addr, and offset = addr mod XLEN/8.
REQ-017 Size SHALL be 1/2/4/8 bytes for B/H/W/D; misaligned means offset+size > XLEN/8.
REQ-018 Illegal means fnc=111, or fnc in {011,110} with XLEN=32; illegal or (misaligned && ALLOW_MISALIGNED=0) SHALL go IDLE->RESP directly with resp_err=1, resp_data=0, no memory access.
REQ-019 Otherwise IDLE->REQ0; mem_req_valid=1 in REQ0 and REQ1 only; REQ0 drives base=addr with low log2(XLEN/8) bits cleared; REQ1 drives base+XLEN/8 (32-bit wrap).
REQ-020 mem_req_addr and mem_req_valid SHALL stay stable until mem_req_ready; REQ0->WAIT0 and REQ1->WAIT1 on handshake.
REQ-021 WAIT0 on mem_resp_valid: capture beat0; go REQ1 if misaligned, else RESP. WAIT1 on mem_resp_valid: capture beat1, go RESP.
REQ-022 mem_resp_valid outside WAIT0/WAIT1 SHALL be ignored.
REQ-023 Result SHALL be ({beat1,beat0} >> 8*offset) truncated to size bytes; beat1 treated as 0 when unused.
REQ-024 Signed fnc (000,001,010,011) SHALL sign-extend from the top loaded bit; 100,101,110 SHALL zero-extend; LD on XLEN=64 needs no extension.
REQ-025 In RESP, resp_valid=1 and resp_data/resp_err SHALL be registered and stable until resp_ready; RESP->IDLE on handshake.
REQ-026 Latency SHALL be min 3 cycles accept-to-resp_valid for an aligned load with mem_req_ready=1 and mem_resp_valid the cycle after mem handshake; +2 cycles for split.
REQ-027 Request acceptance SHALL not be permitted in the same cycle as the resp handshake (next request accepted at earliest one cycle after).

Reset
REQ-028 rst SHALL asynchronously force IDLE; req_ready=1, mem_req_valid=0, mem_req_addr=0, resp_valid=0, resp_data=0, resp_err=0, captured beats=0.
REQ-029 rst asserted mid-operation SHALL abandon the load; a late memory response after release SHALL be ignored per REQ-022.

Verification
REQ-030 XLEN=32, LB addr 0x103, mem word 0x80FF_1234 -> mem_req_addr 0x100, resp_data 0xFFFF_FF80, resp_err 0.
REQ-031 XLEN=32, LHU addr 0x203, words 0xAB00_0000 @0x200, 0x0000_00CD @0x204 -> two mem requests 0x200, 0x204; resp_data 0x0000_CDAB.
REQ-032 XLEN=32, ALLOW_MISALIGNED=0, LW addr 0x102 -> no mem_req_valid, resp_err 1, resp_data 0.
REQ-033 XLEN=64, LWU addr 0x1004, word 0xFEDC_BA98_7654_3210 -> resp_data 0x0000_0000_FEDC_BA98; LW same -> 0xFFFF_FFFF_FEDC_BA98.
REQ-034 Hold mem_req_ready=0 3 cycles and resp_ready=0 2 cycles -> outputs stable throughout, req_ready 0 until resp handshake.
REQ-035 Assert rst in WAIT1 -> all outputs at reset values immediately; following LB completes normally.
